// File: rtl/trng_sample_ctrl.sv
// TRNG sampling controller: synchronizes ring-oscillator taps, XOR-folds them per strobe,
// debiases with Von Neumann pairing, assembles bytes and runs a repetition-count health test.
module trng_sample_ctrl #(
   parameter int SAMPLE_DIV   = 50,
   parameter int REP_LIMIT    = 32,
   parameter int WARMUP_BYTES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] raw,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic [1:0] state,
   output logic       health_fail
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_FAIL   = 2'd3
   } state_t;

   localparam logic [9:0]  DIV_LAST  = 10'(SAMPLE_DIV - 1);
   localparam logic [7:0]  REP_MAX   = 8'(REP_LIMIT);
   localparam logic [15:0] WARM_LAST = 16'(WARMUP_BYTES - 1);

   state_t      state_q;
   logic [7:0]  sync1;
   logic [7:0]  sync2;
   logic [9:0]  div_cnt;
   logic        pair_second;
   logic        first_bit;
   logic [7:0]  rep_cnt;
   logic        last_bit;
   logic [7:0]  asm_q;
   logic [2:0]  bit_cnt;
   logic        byte_rdy;
   logic [15:0] warm_cnt;

   logic        active;
   logic        strobe;
   logic        raw_bit;
   logic [7:0]  rep_next;
   logic        rep_trip;
   logic        db_valid;
   logic        byte_done;
   logic        load;

   assign state = state_q;

   // Output handshake: a byte moves on any cycle with out_valid=1 and out_ready=1;
   // out_data is frozen while out_valid=1 and out_ready=0. A completed byte that cannot
   // be loaded parks in the assembler (byte_rdy) and masks the strobe until it moves.
   always_comb begin
      active    = (state_q == ST_WARMUP) || (state_q == ST_RUN);
      strobe    = active && (div_cnt == DIV_LAST) && !byte_rdy;
      raw_bit   = ^sync2;
      rep_next  = 8'd1;
      if ((rep_cnt != 8'd0) && (raw_bit == last_bit)) begin
         rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 8'd1;
      end
      rep_trip  = strobe && (rep_next == REP_MAX);
      db_valid  = strobe && pair_second && (first_bit != raw_bit);
      byte_done = db_valid && (bit_cnt == 3'd7);
      load      = byte_rdy && (!out_valid || out_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sync1       <= 8'h00;
         sync2       <= 8'h00;
         div_cnt     <= 10'd0;
         pair_second <= 1'b0;
         first_bit   <= 1'b0;
         rep_cnt     <= 8'd0;
         last_bit    <= 1'b0;
         asm_q       <= 8'h00;
         bit_cnt     <= 3'd0;
         byte_rdy    <= 1'b0;
         warm_cnt    <= 16'd0;
         out_data    <= 8'h00;
         out_valid   <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (!en || (state_q == ST_IDLE)) begin
            // Dropping en wins over any same-cycle completion; IDLE keeps the datapath cleared.
            state_q     <= en ? ST_WARMUP : ST_IDLE;
            div_cnt     <= 10'd0;
            pair_second <= 1'b0;
            first_bit   <= 1'b0;
            rep_cnt     <= 8'd0;
            last_bit    <= 1'b0;
            asm_q       <= 8'h00;
            bit_cnt     <= 3'd0;
            byte_rdy    <= 1'b0;
            warm_cnt    <= 16'd0;
            out_valid   <= 1'b0;
            health_fail <= 1'b0;
         end else if (state_q == ST_FAIL) begin
            out_valid <= 1'b0;
         end else if (rep_trip) begin
            state_q     <= ST_FAIL;
            health_fail <= 1'b1;
            out_valid   <= 1'b0;
            byte_rdy    <= 1'b0;
         end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? 10'd0 : div_cnt + 10'd1;
            if (strobe) begin
               rep_cnt     <= rep_next;
               last_bit    <= raw_bit;
               pair_second <= ~pair_second;
               if (!pair_second) begin
                  first_bit <= raw_bit;
               end
            end
            // Pair 10 yields 1 and 01 yields 0, i.e. the first bit of an unequal pair.
            if (db_valid) begin
               asm_q   <= {first_bit, asm_q[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (out_valid && out_ready) begin
               out_valid <= 1'b0;
            end
            if (load) begin
               out_data  <= asm_q;
               out_valid <= 1'b1;
               byte_rdy  <= 1'b0;
            end
            if (state_q == ST_WARMUP) begin
               if (WARMUP_BYTES == 0) begin
                  state_q <= ST_RUN;
               end else if (byte_done) begin
                  warm_cnt <= warm_cnt + 16'd1;
                  if (warm_cnt == WARM_LAST) begin
                     state_q <= ST_RUN;
                  end
               end
            end else if (byte_done) begin
               byte_rdy <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl: two instances (no warmup / two warmup bytes)
// driven by parity-controlled raw taps so each strobe sees a chosen XOR bit.
module tb_trng_sample_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] raw = 8'h00;
   logic       out_ready = 1'b0;

   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic [1:0] state_a, state_b;
   logic       hf_a, hf_b;

   int          n_checks = 0;
   int          n_err = 0;
   int          cyc = -1;
   logic [15:0] pat_word = 16'h0000;
   logic        const_raw = 1'b0;
   logic [7:0]  exp_q[$];

   trng_sample_ctrl #(.SAMPLE_DIV(4), .REP_LIMIT(32), .WARMUP_BYTES(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .raw(raw), .out_ready(out_ready),
      .out_data(data_a), .out_valid(valid_a), .state(state_a), .health_fail(hf_a)
   );

   trng_sample_ctrl #(.SAMPLE_DIV(4), .REP_LIMIT(32), .WARMUP_BYTES(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .raw(raw), .out_ready(out_ready),
      .out_data(data_b), .out_valid(valid_b), .state(state_b), .health_fail(hf_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Slot j is the XOR bit seen by the (j+1)-th strobe; each pair encodes one word bit b as (b, ~b).
   function automatic logic pat_bit(input int j);
      logic [15:0] w;
      w = pat_word;
      return w[(j / 2) % 16] ^ (j % 2 == 1);
   endfunction

   task automatic set_raw(input logic v);
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      if ((^r) != v) r[0] = ~r[0];
      raw = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 0 && cyc % 4 == 0) set_raw(const_raw ? 1'b0 : pat_bit(cyc / 4));
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      en = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic start_phase(input logic [15:0] w, input logic rdy, input logic cst);
      pat_word = w;
      const_raw = cst;
      out_ready = rdy;
      set_raw(cst ? 1'b0 : pat_bit(0));
      en = 1'b1;
      cyc = -1;
   endtask

   initial begin
      logic [15:0] rnd_word;

      // Reset values while rst_n is held low
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", state_a, 2'd0);
      check("rst_valid", valid_a, 1'b0);
      check("rst_data", data_a, 8'h00);
      check("rst_health", hf_a, 1'b0);
      rst_n = 1'b1;

      // Pairs 01 -> 0x00 bytes every 64 cycles; WARMUP_BYTES 0 vs 2
      start_phase(16'h0000, 1'b1, 1'b0);
      step();
      check("a_warmup_entry", state_a, 2'd1);
      check("b_warmup_entry", state_b, 2'd1);
      step();
      check("a_run_immediate", state_a, 2'd2);
      run_to(64);
      check("a_valid_pre", valid_a, 1'b0);
      step();
      check("a_valid_byte1", valid_a, 1'b1);
      check("a_data_byte1", data_a, 8'h00);
      step();
      check("a_valid_clear", valid_a, 1'b0);
      run_to(127);
      check("b_still_warmup", state_b, 2'd1);
      step();
      check("b_run_after2", state_b, 2'd2);
      check("a_valid_gap", valid_a, 1'b0);
      step();
      check("a_valid_byte2", valid_a, 1'b1);
      check("b_byte2_dropped", valid_b, 1'b0);

      // Pairs 10 -> third byte 0xFF presented after two discarded
      do_reset();
      start_phase(16'hFFFF, 1'b1, 1'b0);
      run_to(65);
      check("a_data_ff", data_a, 8'hFF);
      check("b_drop1", valid_b, 1'b0);
      run_to(129);
      check("b_drop2", valid_b, 1'b0);
      run_to(192);
      check("b_valid_pre3", valid_b, 1'b0);
      step();
      check("b_valid_byte3", valid_b, 1'b1);
      check("b_data_byte3", data_b, 8'hFF);

      // Constant XOR -> FAIL on the 32nd strobe, clears only when en drops
      do_reset();
      start_phase(16'h0000, 1'b1, 1'b1);
      run_to(127);
      check("a_pre_trip_state", state_a, 2'd2);
      check("a_pre_trip_health", hf_a, 1'b0);
      step();
      check("a_fail_state", state_a, 2'd3);
      check("a_fail_health", hf_a, 1'b1);
      check("a_fail_valid", valid_a, 1'b0);
      check("b_fail_state", state_b, 2'd3);
      run_to(140);
      check("a_fail_hold", state_a, 2'd3);
      en = 1'b0;
      step();
      check("a_fail_to_idle", state_a, 2'd0);
      check("a_health_clr", hf_a, 1'b0);

      // Backpressure: byte 2 parks, strobes stop, then loads the cycle after ready
      do_reset();
      exp_q = {8'hA5, 8'h3C, 8'h3C};
      start_phase(16'h3CA5, 1'b0, 1'b0);
      run_to(65);
      check("bp_valid1", valid_a, 1'b1);
      check("bp_data1", data_a, exp_q.pop_front());
      run_to(128);
      const_raw = 1'b1;
      run_to(200);
      check("bp_stable_mid", data_a, 8'hA5);
      run_to(319);
      const_raw = 1'b0;
      check("bp_no_strobe_state", state_a, 2'd2);
      check("bp_no_strobe_health", hf_a, 1'b0);
      check("bp_b_kept_sampling", hf_b, 1'b1);
      step();
      check("bp_stable_end", data_a, 8'hA5);
      out_ready = 1'b1;
      step();
      check("bp_held_valid", valid_a, 1'b1);
      check("bp_held_data", data_a, exp_q.pop_front());
      step();
      check("bp_held_taken", valid_a, 1'b0);
      run_to(384);
      check("bp_resume_pre", valid_a, 1'b0);
      step();
      check("bp_resume_valid", valid_a, 1'b1);
      check("bp_resume_data", data_a, exp_q.pop_front());

      // Random word, asynchronous reset mid-byte, warmup restarts from zero
      do_reset();
      rnd_word = 16'($urandom_range(0, 65535));
      start_phase(rnd_word, 1'b0, 1'b0);
      run_to(65);
      check("rnd_data1", data_a, {8'h00, rnd_word[7:0]});
      run_to(100);
      rst_n = 1'b0;
      #2;
      check("async_state", state_a, 2'd0);
      check("async_valid", valid_a, 1'b0);
      check("async_data", data_a, 8'h00);
      check("async_state_b", state_b, 2'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_phase(rnd_word, 1'b1, 1'b0);
      step();
      check("restart_warmup", state_b, 2'd1);
      run_to(127);
      check("restart_warm_cnt", state_b, 2'd1);
      step();
      check("restart_run", state_b, 2'd2);

      // en dropped on the completion cycle: byte never presented
      do_reset();
      start_phase(16'h5A5A, 1'b1, 1'b0);
      run_to(63);
      check("drop_pre_state", state_a, 2'd2);
      en = 1'b0;
      step();
      check("drop_idle", state_a, 2'd0);
      check("drop_valid", valid_a, 1'b0);
      step();
      check("drop_not_presented", valid_a, 1'b0);
      run_to(80);
      check("idle_no_valid", valid_a, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/trng_sample_ctrl.md
TRNG_SAMPLE_CTRL -- requirements
Module: trng_sample_ctrl

Interface
REQ-001 Parameter SAMPLE_DIV, default 50: clk cycles between raw samples; legal range 4..1023.
REQ-002 Parameter REP_LIMIT, default 32: consecutive identical raw bits that trip the health test; legal range 2..255.
REQ-003 Parameter WARMUP_BYTES, default 4: assembled bytes discarded after start; 0 is legal.
REQ-004 Port clk, input, 1: single system clock, rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port en, input, 1: run request; level sensitive.
REQ-007 Port raw, input, 8: free-running ring-oscillator taps; asynchronous to clk.
REQ-008 Port out_ready, input, 1: consumer accepts out_data.
REQ-009 Port out_data, output, 8: debiased random byte.
REQ-010 Port out_valid, output, 1: out_data holds an unconsumed byte.
REQ-011 Port state, output, 2: current FSM state (IDLE=0, WARMUP=1, RUN=2, FAIL=3).
REQ-012 Port health_fail, output, 1: sticky health-test failure flag.

Function
REQ-013 Each raw bit SHALL pass a 2-flop synchronizer; the synchronized bits SHALL NOT be used until 2 cycles after the raw change.
REQ-014 A prescaler SHALL assert a sample strobe once every SAMPLE_DIV cycles while state is WARMUP or RUN; the prescaler SHALL reset to 0 on entry to WARMUP.
REQ-015 On each strobe, raw bit b SHALL be the XOR of all 8 synchronized taps.
REQ-016 Von Neumann pairing: strobes alternate first/second bit; pair 01 -> 0, 10 -> 1, 00/11 discarded; pair phase SHALL reset to first on entry to WARMUP.
REQ-017 Debiased bits SHALL shift into an 8-bit assembler LSB-first; a 3-bit count wraps 7->0 and marks byte-complete.
REQ-018 In WARMUP, completed bytes SHALL be discarded and counted; after WARMUP_BYTES completions (or immediately if 0) the FSM SHALL go to RUN on the next cycle.
REQ-019 In RUN, a completed byte SHALL load out_data and set out_valid on the cycle after completion when out_valid=0 or out_ready=1 in that cycle.
REQ-020 If a byte completes while out_valid=1 and out_ready=0, the assembler SHALL hold it and the strobe SHALL be suppressed (no sampling) until the byte is loaded.
REQ-021 Handshake: transfer occurs in a cycle with out_valid=1 and out_ready=1; out_valid SHALL clear next cycle unless a new byte loads in the same cycle; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Health test: a repetition counter SHALL count consecutive identical raw b values (every strobe, before pairing), saturating at REP_LIMIT; on reaching REP_LIMIT in WARMUP or RUN, the FSM SHALL go to FAIL, set health_fail, and clear out_valid.
REQ-023 Transitions: IDLE->WARMUP when en=1; WARMUP/RUN->IDLE when en=0 (takes precedence over completions the same cycle); FAIL->IDLE only when en=0.
REQ-024 Entering IDLE SHALL clear out_valid, assembler, counters and pair phase; health_fail SHALL clear only on FAIL->IDLE.
REQ-025 In IDLE and FAIL no strobes SHALL occur and out_valid SHALL remain 0.

Reset
REQ-026 While rst_n=0: state=IDLE, out_data=8'h00, out_valid=0, health_fail=0, all counters, synchronizers and assembler zero.
REQ-027 rst_n assertion mid-operation SHALL take effect immediately without waiting for clk; deassertion is assumed synchronous to clk externally.

Verification
REQ-028 SAMPLE_DIV=4, WARMUP_BYTES=0, en=1, raw alternating XOR 0,1 per strobe -> every pair 01 -> bytes 8'h00 on out_valid, one byte per 64 cycles with out_ready=1.
REQ-029 XOR pattern 1,0 per pair, WARMUP_BYTES=2 -> first two bytes dropped, third byte 8'hFF presented; state 1 then 2.
REQ-030 raw held constant, REP_LIMIT=32 -> FAIL after 32 strobes, health_fail=1, out_valid=0; en=0 -> IDLE, health_fail=0.
REQ-031 out_ready=0 for 3 byte periods -> out_data stable, no strobes after the second byte completes; out_ready=1 -> held byte loads next cycle, sampling resumes.
REQ-032 Random raw with rst_n pulsed low mid-byte -> all outputs reset values immediately; after release with en=1, WARMUP restarts with count 0.
REQ-033 en dropped on the cycle a byte completes in RUN -> state IDLE, out_valid=0, byte not presented.
